// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg
// Shared types for the writeback stage: the regfilemux writeback-source
// select encoding and the RV32I load funct3 values.
package wb_regfile_pkg;

  // Writeback source select driven by the control word in MEM/WB.
  typedef enum logic [3:0] {
    SEL_ALU_OUT  = 4'd0,
    SEL_BR_EN    = 4'd1,
    SEL_U_IMM    = 4'd2,
    SEL_LW       = 4'd3,
    SEL_PC_PLUS4 = 4'd4,
    SEL_LB       = 4'd5,
    SEL_LBU      = 4'd6,
    SEL_LH       = 4'd7,
    SEL_LHU      = 4'd8
  } regfilemux_sel_t;

  // RV32I load funct3 encodings.
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
// Bundles the MEM/WB inputs, the decode-stage read ports and the forwarding
// outputs of the writeback stage.
//   slave  : the writeback stage (consumes MEM/WB, serves reads/forwarding)
//   master : the surrounding pipeline (drives MEM/WB and read addresses)
interface wb_regfile_if;
  logic        wb_valid;
  logic        load_regfile;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [3:0]  regfilemux_sel;
  logic [31:0] alu_out;
  logic [31:0] mdr_out;
  logic        br_en;
  logic [31:0] u_imm;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  modport slave (
    input  wb_valid, load_regfile, rd, pc, regfilemux_sel, alu_out, mdr_out,
           br_en, u_imm, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data
  );

  modport master (
    output wb_valid, load_regfile, rd, pc, regfilemux_sel, alu_out, mdr_out,
           br_en, u_imm, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/wb_load_extend.sv
// wb_load_extend
// Purely combinational byte/halfword select and sign/zero extension of an
// aligned load word.
//   mdr            in  32  raw aligned load word
//   offset         in  2   byte offset within the word (alu_out[1:0])
//   regfilemux_sel in  4   load kind (lb/lbu/lh/lhu; anything else passes mdr)
//   data           out 32  extended load value
module wb_load_extend
  import wb_regfile_pkg::*;
(
  input  logic [31:0]     mdr,
  input  logic [1:0]      offset,
  input  regfilemux_sel_t regfilemux_sel,
  output logic [31:0]     data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Halfword accesses use only offset[1]; offset[0] is deliberately ignored.
  always_comb begin
    byte_val = mdr[7:0];
    case (offset)
      2'd0: byte_val = mdr[7:0];
      2'd1: byte_val = mdr[15:8];
      2'd2: byte_val = mdr[23:16];
      2'd3: byte_val = mdr[31:24];
      default: byte_val = mdr[7:0];
    endcase
    half_val = offset[1] ? mdr[31:16] : mdr[15:0];
  end

  always_comb begin
    data = mdr;
    case (regfilemux_sel)
      SEL_LB:  data = {{24{byte_val[7]}}, byte_val};
      SEL_LBU: data = {24'b0, byte_val};
      SEL_LH:  data = {{16{half_val[15]}}, half_val};
      SEL_LHU: data = {16'b0, half_val};
      default: data = mdr;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
// Writeback stage plus the 32x32 architectural register file. Selects the
// writeback value, commits it one edge later, serves two combinational read
// ports with optional same-cycle write-through, and counts retirements.
//   clk, rst  clock and synchronous active-high reset
//   bus       wb_regfile_if.slave: MEM/WB inputs, rs1/rs2 reads, forwarding
//   instret   retired-instruction count (INSTRET_W bits, wraps)
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int INSTRET_W = 64,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_regfile_if.slave          bus,
  output logic [INSTRET_W-1:0] instret
);

  regfilemux_sel_t sel;
  logic [31:0]     load_data;
  logic [31:0]     wb_data;
  logic            we;
  // x0 has no storage; it is hardwired to zero on the read side.
  logic [31:0]     regs [31:1];

  assign sel = regfilemux_sel_t'(bus.regfilemux_sel);
  assign we  = bus.wb_valid & bus.load_regfile & (bus.rd != 5'd0);

  wb_load_extend u_load_extend (
    .mdr            (bus.mdr_out),
    .offset         (bus.alu_out[1:0]),
    .regfilemux_sel (sel),
    .data           (load_data)
  );

  // Unlisted select encodings fall back to the ALU result.
  always_comb begin
    wb_data = bus.alu_out;
    case (sel)
      SEL_ALU_OUT:  wb_data = bus.alu_out;
      SEL_BR_EN:    wb_data = {31'b0, bus.br_en};
      SEL_U_IMM:    wb_data = bus.u_imm;
      SEL_PC_PLUS4: wb_data = bus.pc + 32'd4;
      SEL_LW,
      SEL_LB,
      SEL_LBU,
      SEL_LH,
      SEL_LHU:      wb_data = load_data;
      default:      wb_data = bus.alu_out;
    endcase
  end

  // Reset has priority, so a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we) begin
      regs[bus.rd] <= wb_data;
    end
  end

  // Retirement counts every valid MEM/WB slot, writing or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (bus.wb_valid) begin
      instret <= instret + INSTRET_W'(1);
    end
  end

  // Read ports: x0 reads zero; with bypass enabled a read of the register
  // being committed this cycle sees the new value.
  always_comb begin
    bus.rs1_data = '0;
    if (bus.rs1_addr != 5'd0) begin
      if (BYPASS_EN && we && (bus.rs1_addr == bus.rd)) bus.rs1_data = wb_data;
      else                                             bus.rs1_data = regs[bus.rs1_addr];
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    if (bus.rs2_addr != 5'd0) begin
      if (BYPASS_EN && we && (bus.rs2_addr == bus.rd)) bus.rs2_data = wb_data;
      else                                             bus.rs2_data = regs[bus.rs2_addr];
    end
  end

  // Forwarding outputs are zeroed when nothing commits.
  always_comb begin
    bus.fwd_valid = we;
    bus.fwd_rd    = we ? bus.rd : 5'd0;
    bus.fwd_data  = we ? wb_data : 32'd0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Scoreboard bench for wb_regfile: each scenario task pushes expected values
// when it drives stimulus and pops/compares them when the DUT output is due.
// A second instance with BYPASS_EN=0 shares the same stimulus.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  typedef enum int {OBS_RS1, OBS_RS2, OBS_RS2_NB, OBS_FWD_VALID, OBS_FWD_RD,
                    OBS_FWD_DATA, OBS_INSTRET} obs_t;

  typedef struct {
    string       name;
    obs_t        id;
    logic [63:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] instret;
  logic [63:0] instret_nb;
  int          checks;
  int          failures;
  logic [63:0] exp_instret;
  exp_t        expq[$];

  wb_regfile_if bus ();
  wb_regfile_if bus_nb ();

  wb_regfile #(.INSTRET_W(64), .BYPASS_EN(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .instret (instret)
  );

  wb_regfile #(.INSTRET_W(64), .BYPASS_EN(1'b0)) dut_nb (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_nb),
    .instret (instret_nb)
  );

  assign bus_nb.wb_valid       = bus.wb_valid;
  assign bus_nb.load_regfile   = bus.load_regfile;
  assign bus_nb.rd             = bus.rd;
  assign bus_nb.pc             = bus.pc;
  assign bus_nb.regfilemux_sel = bus.regfilemux_sel;
  assign bus_nb.alu_out        = bus.alu_out;
  assign bus_nb.mdr_out        = bus.mdr_out;
  assign bus_nb.br_en          = bus.br_en;
  assign bus_nb.u_imm          = bus.u_imm;
  assign bus_nb.rs1_addr       = bus.rs1_addr;
  assign bus_nb.rs2_addr       = bus.rs2_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] observe(obs_t id);
    case (id)
      OBS_RS1:       return {32'b0, bus.rs1_data};
      OBS_RS2:       return {32'b0, bus.rs2_data};
      OBS_RS2_NB:    return {32'b0, bus_nb.rs2_data};
      OBS_FWD_VALID: return {63'b0, bus.fwd_valid};
      OBS_FWD_RD:    return {59'b0, bus.fwd_rd};
      OBS_FWD_DATA:  return {32'b0, bus.fwd_data};
      OBS_INSTRET:   return instret;
      default:       return 64'hx;
    endcase
  endfunction

  task automatic idle();
    bus.wb_valid       = 1'b0;
    bus.load_regfile   = 1'b0;
    bus.rd             = 5'd0;
    bus.pc             = 32'd0;
    bus.regfilemux_sel = SEL_ALU_OUT;
    bus.alu_out        = 32'd0;
    bus.mdr_out        = 32'd0;
    bus.br_en          = 1'b0;
    bus.u_imm          = 32'd0;
    bus.rs1_addr       = 5'd0;
    bus.rs2_addr       = 5'd0;
  endtask

  // Advance one rising edge, tracking the expected retirement count.
  task automatic tick();
    if (rst)               exp_instret = 64'd0;
    else if (bus.wb_valid) exp_instret = exp_instret + 64'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    bus.wb_valid       = 1'b1;
    bus.load_regfile   = 1'b1;
    bus.rd             = r;
    bus.regfilemux_sel = SEL_ALU_OUT;
    bus.alu_out        = v;
    tick();
    bus.wb_valid       = 1'b0;
    bus.load_regfile   = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [63:0] got;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      bus.rs1_addr = 5'(r);
      bus.rs2_addr = 5'(r);
      #2;
      expq.push_back('{$sformatf("reset_rs1_x%0d", r), OBS_RS1, 64'd0});
      expq.push_back('{$sformatf("reset_rs2_x%0d", r), OBS_RS2, 64'd0});
      while (expq.size() > 0) begin
        e = expq.pop_front();
        got = observe(e.id);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
        end
      end
    end
    expq.push_back('{"reset_instret", OBS_INSTRET, 64'd0});
    expq.push_back('{"reset_fwd_valid", OBS_FWD_VALID, 64'd0});
    expq.push_back('{"reset_fwd_data", OBS_FWD_DATA, 64'd0});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_write_bypass();
    exp_t e;
    logic [63:0] got;
    idle();
    bus.wb_valid       = 1'b1;
    bus.load_regfile   = 1'b1;
    bus.rd             = 5'd5;
    bus.regfilemux_sel = SEL_ALU_OUT;
    bus.alu_out        = 32'hDEADBEEF;
    bus.rs2_addr       = 5'd5;
    #2;
    expq.push_back('{"bypass_rs2", OBS_RS2, 64'h00000000DEADBEEF});
    expq.push_back('{"nobypass_rs2_old", OBS_RS2_NB, 64'd0});
    expq.push_back('{"fwd_valid_x5", OBS_FWD_VALID, 64'd1});
    expq.push_back('{"fwd_rd_x5", OBS_FWD_RD, 64'd5});
    expq.push_back('{"fwd_data_x5", OBS_FWD_DATA, 64'h00000000DEADBEEF});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
    tick();
    idle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd5;
    #2;
    expq.push_back('{"read_x5_rs1", OBS_RS1, 64'h00000000DEADBEEF});
    expq.push_back('{"read_x5_nobypass", OBS_RS2_NB, 64'h00000000DEADBEEF});
    expq.push_back('{"idle_fwd_valid", OBS_FWD_VALID, 64'd0});
    expq.push_back('{"idle_fwd_rd", OBS_FWD_RD, 64'd0});
    expq.push_back('{"instret_after_x5", OBS_INSTRET, exp_instret});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
    // Both ports bypassing at once to a different register.
    bus.wb_valid     = 1'b1;
    bus.load_regfile = 1'b1;
    bus.rd           = 5'd9;
    bus.alu_out      = 32'h0BADF00D;
    bus.rs1_addr     = 5'd9;
    bus.rs2_addr     = 5'd9;
    #2;
    expq.push_back('{"dual_bypass_rs1", OBS_RS1, 64'h000000000BADF00D});
    expq.push_back('{"dual_bypass_rs2", OBS_RS2, 64'h000000000BADF00D});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
    tick();
    idle();
  endtask

  task automatic test_x0();
    exp_t e;
    logic [63:0] got;
    idle();
    bus.wb_valid     = 1'b1;
    bus.load_regfile = 1'b1;
    bus.rd           = 5'd0;
    bus.alu_out      = 32'h12345678;
    bus.rs1_addr     = 5'd0;
    #2;
    expq.push_back('{"x0_bypass_rs1", OBS_RS1, 64'd0});
    expq.push_back('{"x0_fwd_valid", OBS_FWD_VALID, 64'd0});
    expq.push_back('{"x0_fwd_data", OBS_FWD_DATA, 64'd0});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
    tick();
    idle();
    bus.rs1_addr = 5'd0;
    #2;
    expq.push_back('{"x0_read_after", OBS_RS1, 64'd0});
    expq.push_back('{"x0_instret", OBS_INSTRET, exp_instret});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_loads();
    exp_t e;
    logic [63:0] got;
    logic [3:0]  sels [8];
    logic [1:0]  offs [8];
    logic [31:0] exps [8];
    sels = '{SEL_LB, SEL_LBU, SEL_LH, SEL_LHU, SEL_LH, SEL_LW, SEL_LB, SEL_LBU};
    offs = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2, 2'd0, 2'd3};
    exps = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
             32'hFFFF80FF, 32'h80FF7F01, 32'h00000001, 32'h00000080};
    for (int i = 0; i < 8; i++) begin
      idle();
      bus.wb_valid       = 1'b1;
      bus.load_regfile   = 1'b1;
      bus.rd             = 5'd10;
      bus.mdr_out        = 32'h80FF7F01;
      bus.regfilemux_sel = sels[i];
      bus.alu_out        = {30'h04000000, offs[i]};
      #2;
      expq.push_back('{$sformatf("load%0d_fwd_data", i), OBS_FWD_DATA, {32'b0, exps[i]}});
      while (expq.size() > 0) begin
        e = expq.pop_front();
        got = observe(e.id);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
        end
      end
      tick();
      idle();
      bus.rs1_addr = 5'd10;
      #2;
      expq.push_back('{$sformatf("load%0d_read_x10", i), OBS_RS1, {32'b0, exps[i]}});
      while (expq.size() > 0) begin
        e = expq.pop_front();
        got = observe(e.id);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_wb_sources();
    exp_t e;
    logic [63:0] got;
    logic [3:0]  sels [4];
    logic [31:0] exps [4];
    sels = '{SEL_PC_PLUS4, SEL_BR_EN, SEL_U_IMM, 4'hF};
    exps = '{32'h00000000, 32'h00000001, 32'hABCDE000, 32'h13572468};
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.wb_valid       = 1'b1;
      bus.load_regfile   = 1'b1;
      bus.rd             = 5'd3;
      bus.pc             = 32'hFFFFFFFC;
      bus.br_en          = 1'b1;
      bus.u_imm          = 32'hABCDE000;
      bus.alu_out        = 32'h13572468;
      bus.regfilemux_sel = sels[i];
      #2;
      expq.push_back('{$sformatf("src%0d_fwd_data", i), OBS_FWD_DATA, {32'b0, exps[i]}});
      while (expq.size() > 0) begin
        e = expq.pop_front();
        got = observe(e.id);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_retire_and_reset();
    exp_t e;
    logic [63:0] got;
    logic [12:0] pattern;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pattern = 13'b1101110110111;
    for (int i = 0; i < 13; i++) begin
      bus.wb_valid     = pattern[i];
      bus.load_regfile = 1'b0;
      tick();
    end
    idle();
    #2;
    expq.push_back('{"retire_mix_instret", OBS_INSTRET, 64'd10});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
    write_reg(5'd7, 32'h00000077);
    bus.rs1_addr = 5'd7;
    #2;
    expq.push_back('{"x7_before_reset", OBS_RS1, 64'h77});
    expq.push_back('{"instret_before_reset", OBS_INSTRET, 64'd11});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
    rst                = 1'b1;
    bus.wb_valid       = 1'b1;
    bus.load_regfile   = 1'b1;
    bus.rd             = 5'd7;
    bus.regfilemux_sel = SEL_ALU_OUT;
    bus.alu_out        = 32'h55555555;
    tick();
    rst = 1'b0;
    idle();
    bus.rs1_addr = 5'd7;
    #2;
    expq.push_back('{"x7_after_reset", OBS_RS1, 64'd0});
    expq.push_back('{"instret_after_reset", OBS_INSTRET, 64'd0});
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = observe(e.id);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, got, e.exp);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_instret = 64'd0;
    rst         = 1'b1;
    idle();
    test_reset();
    test_write_bypass();
    test_x0();
    test_loads();
    test_wb_sources();
    test_retire_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
